// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory transaction arbiter.
package mem_arbiter_pkg;

   // Owner state: who currently has a transaction in flight on the bus.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } owner_e;

   // One-hot grant values seen on the grant output.
   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_P0   = 2'b01;
   localparam logic [1:0] GRANT_P1   = 2'b10;

   // Consecutive contested port-0 grants tolerated before port 1 is forced.
   localparam int STARVE_LIMIT_DEFAULT = 3;
   localparam int STARVE_CNT_W         = 4;

   // Owner state that corresponds to a requester index.
   function automatic owner_e own_state(input int port);
      return (port == 0) ? ST_OWN0 : ST_OWN1;
   endfunction

endpackage

// File: rtl/mem_arb_starve.sv
// Starvation guard for port 1: counts port-0 grants that were won while
// port 1 was waiting, and raises o_force once the limit is reached.
module mem_arb_starve
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT   // legal 1..15
)(
   input  logic clk,
   input  logic rst_n,
   input  logic i_inc,     // contested, unlocked port-0 grant this cycle
   input  logic i_clr,     // port-1 grant this cycle
   output logic o_force    // port 1 must win the next unlocked arbitration
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] r_count;

   // Saturating counter; a port-1 grant always wins over an increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count < LIMIT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_force = (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the bus interface transaction port.
// Port 0 (CPU) has fixed priority, port 1 (debug/DMA) is protected from
// starvation, and p0_lock keeps port-0 read-modify-write sequences atomic.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
)(
   input  logic        clk,
   input  logic        rst_n,
   // port 0: CPU core
   input  logic        p0_read,
   input  logic        p0_write,
   input  logic [15:0] p0_addr,
   input  logic        p0_io,
   input  logic [7:0]  p0_wdata,
   input  logic        p0_lock,
   output logic [7:0]  p0_rdata,
   output logic        p0_done,
   // port 1: debug/DMA host
   input  logic        p1_read,
   input  logic        p1_write,
   input  logic [15:0] p1_addr,
   input  logic        p1_io,
   input  logic [7:0]  p1_wdata,
   output logic [7:0]  p1_rdata,
   output logic        p1_done,
   // bus interface transaction port
   output logic        memory_read,
   output logic        memory_write,
   output logic [15:0] memory_addr,
   output logic        memory_io,
   output logic [7:0]  memory_wdata,
   input  logic [7:0]  memory_rdata,
   input  logic        memory_done,
   output logic [1:0]  grant
);

   // Per-port views of the requester signals, indexed by port number.
   logic [1:0]  w_rd;
   logic [1:0]  w_wr;
   logic [1:0]  w_io;
   logic [15:0] w_addr [2];
   logic [7:0]  w_wdata [2];
   logic [1:0]  w_req;
   logic [1:0]  w_done;
   logic [7:0]  w_rdata_out [2];
   logic [7:0]  r_rdata [2];

   owner_e      r_state;
   logic [1:0]  r_grant;
   logic        r_mem_read;
   logic        r_mem_write;
   logic [15:0] r_mem_addr;
   logic        r_mem_io;
   logic [7:0]  r_mem_wdata;

   logic        w_arb;
   logic        w_force;
   logic        w_pick0;
   logic        w_pick1;
   logic        w_sel;
   logic        w_own;
   logic        w_inc;

   assign w_rd       = {p1_read,  p0_read};
   assign w_wr       = {p1_write, p0_write};
   assign w_io       = {p1_io,    p0_io};
   assign w_addr[0]  = p0_addr;
   assign w_addr[1]  = p1_addr;
   assign w_wdata[0] = p0_wdata;
   assign w_wdata[1] = p1_wdata;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         localparam owner_e OWN_ST = own_state(gi);

         assign w_req[gi]  = w_rd[gi] | w_wr[gi];
         // Completion is only forwarded to the port that owns the bus.
         assign w_done[gi] = (r_state == OWN_ST) && memory_done;

         // Hold the last read data for this port after its completion.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rdata[gi] <= '0;
            end else if (w_done[gi]) begin
               r_rdata[gi] <= memory_rdata;
            end
         end

         // Bypass so read data is already valid in the done cycle.
         assign w_rdata_out[gi] = w_done[gi] ? memory_rdata : r_rdata[gi];
      end
   endgenerate

   // Arbitration happens only in IDLE. Lock makes port 0 the only candidate;
   // otherwise port 1 wins when port 0 is quiet or the starve guard fires.
   assign w_arb   = (r_state == ST_IDLE);
   assign w_pick1 = w_arb && !p0_lock && w_req[1] && (!w_req[0] || w_force);
   assign w_pick0 = w_arb && w_req[0] && !w_pick1;
   assign w_sel   = w_pick1;
   assign w_own   = (r_state == ST_OWN1);

   // Only unlocked port-0 wins over a waiting port 1 count toward starvation.
   assign w_inc   = w_pick0 && w_req[1] && !p0_lock;

   mem_arb_starve #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_inc),
      .i_clr   (w_pick1),
      .o_force (w_force)
   );

   // Owner FSM with registered bus outputs; a done cycle always returns to
   // IDLE so requests seen during it wait for the next IDLE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_grant     <= GRANT_NONE;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_io    <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pick0 || w_pick1) begin
                  r_state     <= w_sel ? ST_OWN1 : ST_OWN0;
                  r_grant     <= w_sel ? GRANT_P1 : GRANT_P0;
                  // Read takes precedence when both strobes are raised.
                  r_mem_read  <= w_rd[w_sel];
                  r_mem_write <= w_wr[w_sel] && !w_rd[w_sel];
                  r_mem_addr  <= w_addr[w_sel];
                  r_mem_io    <= w_io[w_sel];
                  r_mem_wdata <= w_wdata[w_sel];
               end
            end
            ST_OWN0, ST_OWN1: begin
               r_mem_addr  <= w_addr[w_own];
               r_mem_io    <= w_io[w_own];
               r_mem_wdata <= w_wdata[w_own];
               if (memory_done) begin
                  r_state     <= ST_IDLE;
                  r_grant     <= GRANT_NONE;
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_grant     <= GRANT_NONE;
               r_mem_read  <= 1'b0;
               r_mem_write <= 1'b0;
            end
         endcase
      end
   end

   assign memory_read  = r_mem_read;
   assign memory_write = r_mem_write;
   assign memory_addr  = r_mem_addr;
   assign memory_io    = r_mem_io;
   assign memory_wdata = r_mem_wdata;
   assign grant        = r_grant;

   assign p0_done  = w_done[0];
   assign p1_done  = w_done[1];
   assign p0_rdata = w_rdata_out[0];
   assign p1_rdata = w_rdata_out[1];

   // Sanity properties on the outputs.
   a_done_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
      !(p0_done && p1_done));
   a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      (grant != 2'b11));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus
// hand-written sequences for starvation, lock, reset and stray completions.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        p0_read, p0_write, p0_io, p0_lock;
   logic [15:0] p0_addr;
   logic [7:0]  p0_wdata, p0_rdata;
   logic        p0_done;
   logic        p1_read, p1_write, p1_io;
   logic [15:0] p1_addr;
   logic [7:0]  p1_wdata, p1_rdata;
   logic        p1_done;
   logic        memory_read, memory_write, memory_io, memory_done;
   logic [15:0] memory_addr;
   logic [7:0]  memory_wdata, memory_rdata;
   logic [1:0]  grant;

   int n_pass  = 0;
   int n_total = 0;

   mem_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .p0_read      (p0_read),
      .p0_write     (p0_write),
      .p0_addr      (p0_addr),
      .p0_io        (p0_io),
      .p0_wdata     (p0_wdata),
      .p0_lock      (p0_lock),
      .p0_rdata     (p0_rdata),
      .p0_done      (p0_done),
      .p1_read      (p1_read),
      .p1_write     (p1_write),
      .p1_addr      (p1_addr),
      .p1_io        (p1_io),
      .p1_wdata     (p1_wdata),
      .p1_rdata     (p1_rdata),
      .p1_done      (p1_done),
      .memory_read  (memory_read),
      .memory_write (memory_write),
      .memory_addr  (memory_addr),
      .memory_io    (memory_io),
      .memory_wdata (memory_wdata),
      .memory_rdata (memory_rdata),
      .memory_done  (memory_done),
      .grant        (grant)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ctl fields are {read, write, io}
   typedef struct {
      logic [2:0]  p0_ctl;
      logic [15:0] p0_addr;
      logic [7:0]  p0_wd;
      logic [2:0]  p1_ctl;
      logic [15:0] p1_addr;
      logic [7:0]  p1_wd;
      logic        lock;
      int          lat;
      logic [7:0]  rdata;
      int          exp_port;
      logic [2:0]  exp_ctl;
      logic [15:0] exp_addr;
      logic [7:0]  exp_wd;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      p0_read = 1'b0; p0_write = 1'b0; p0_io = 1'b0; p0_addr = 16'h0; p0_wdata = 8'h0;
      p1_read = 1'b0; p1_write = 1'b0; p1_io = 1'b0; p1_addr = 16'h0; p1_wdata = 8'h0;
      p0_lock = 1'b0;
   endtask

   task automatic do_reset();
      clear_reqs();
      memory_done  = 1'b0;
      memory_rdata = 8'h00;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   // Called in an IDLE cycle with requests already driven; the next edge
   // must grant 'port'. Returns in the IDLE cycle after completion.
   task automatic do_txn(input string tag, input int port, input logic [2:0] ctl,
                         input logic [15:0] addr, input logic [7:0] wd,
                         input int lat, input logic [7:0] rdat);
      logic [1:0] g;
      g = (port == 0) ? 2'b01 : 2'b10;
      tick();
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".ctl"},   32'({memory_read, memory_write, memory_io}), 32'(ctl));
      chk({tag, ".addr"},  32'(memory_addr), 32'(addr));
      chk({tag, ".wdata"}, 32'(memory_wdata), 32'(wd));
      for (int k = 1; k < lat; k++) begin
         chk({tag, ".nodone"}, 32'({p1_done, p0_done}), 32'h0);
         tick();
      end
      memory_rdata = rdat;
      memory_done  = 1'b1;
      #1;
      chk({tag, ".done"}, 32'({p1_done, p0_done}), 32'(g));
      chk({tag, ".rdata_comb"}, 32'((port == 0) ? p0_rdata : p1_rdata), 32'(rdat));
      tick();
      memory_done  = 1'b0;
      memory_rdata = 8'h00;
      #1;
      chk({tag, ".idle_grant"}, 32'(grant), 32'h0);
      chk({tag, ".idle_rw"}, 32'({memory_read, memory_write}), 32'h0);
      chk({tag, ".idle_done"}, 32'({p1_done, p0_done}), 32'h0);
      chk({tag, ".rdata_reg"}, 32'((port == 0) ? p0_rdata : p1_rdata), 32'(rdat));
      $display("txn %-12s port%0d ctl=%b addr=%h rdata=%h", tag, port, ctl, addr, rdat);
   endtask

   initial begin
      vecs[0] = '{3'b100, 16'h1234, 8'h00, 3'b000, 16'h0000, 8'h00, 1'b0, 6, 8'h5A, 0, 3'b100, 16'h1234, 8'h00};
      vecs[1] = '{3'b000, 16'h0000, 8'h00, 3'b011, 16'h00AB, 8'h3C, 1'b0, 2, 8'h11, 1, 3'b011, 16'h00AB, 8'h3C};
      vecs[2] = '{3'b010, 16'h0010, 8'h77, 3'b100, 16'h0020, 8'h00, 1'b0, 1, 8'h22, 0, 3'b010, 16'h0010, 8'h77};
      vecs[3] = '{3'b101, 16'h8000, 8'h00, 3'b100, 16'h0021, 8'h00, 1'b0, 3, 8'h33, 0, 3'b101, 16'h8000, 8'h00};
      vecs[4] = '{3'b010, 16'hFFFF, 8'hA5, 3'b010, 16'h0022, 8'h5A, 1'b0, 1, 8'h44, 0, 3'b010, 16'hFFFF, 8'hA5};
      vecs[5] = '{3'b100, 16'h0001, 8'h00, 3'b101, 16'h0023, 8'h00, 1'b0, 2, 8'h66, 1, 3'b101, 16'h0023, 8'h00};
      vecs[6] = '{3'b000, 16'h0000, 8'h00, 3'b110, 16'h4444, 8'h12, 1'b0, 1, 8'h77, 1, 3'b100, 16'h4444, 8'h12};
      vecs[7] = '{3'b110, 16'h5555, 8'h34, 3'b000, 16'h0000, 8'h00, 1'b0, 2, 8'h88, 0, 3'b100, 16'h5555, 8'h34};
      vecs[8] = '{3'b010, 16'h0100, 8'h01, 3'b100, 16'h0200, 8'h00, 1'b1, 1, 8'h55, 0, 3'b010, 16'h0100, 8'h01};
      vecs[9] = '{3'b000, 16'h0000, 8'h00, 3'b100, 16'h0201, 8'h00, 1'b0, 4, 8'h99, 1, 3'b100, 16'h0201, 8'h00};

      // Reset state
      clear_reqs();
      memory_done  = 1'b0;
      memory_rdata = 8'h00;
      rst_n = 1'b0;
      tick();
      tick();
      chk("reset.grant", 32'(grant), 32'h0);
      chk("reset.rw",    32'({memory_read, memory_write, memory_io}), 32'h0);
      chk("reset.addr",  32'(memory_addr), 32'h0);
      chk("reset.wdata", 32'(memory_wdata), 32'h0);
      chk("reset.done",  32'({p1_done, p0_done}), 32'h0);
      chk("reset.rdata", 32'({p1_rdata, p0_rdata}), 32'h0);
      rst_n = 1'b1;
      #1;

      // Table of single transactions; the starve counter carries over
      // between rows (rows 2-4 saturate it, row 5 is the forced grant).
      for (int i = 0; i < 10; i++) begin
         {p0_read, p0_write, p0_io} = vecs[i].p0_ctl;
         p0_addr  = vecs[i].p0_addr;
         p0_wdata = vecs[i].p0_wd;
         {p1_read, p1_write, p1_io} = vecs[i].p1_ctl;
         p1_addr  = vecs[i].p1_addr;
         p1_wdata = vecs[i].p1_wd;
         p0_lock  = vecs[i].lock;
         do_txn($sformatf("vec%0d", i), vecs[i].exp_port, vecs[i].exp_ctl,
                vecs[i].exp_addr, vecs[i].exp_wd, vecs[i].lat, vecs[i].rdata);
         clear_reqs();
      end

      // Simultaneous requests with counter 0: port 0 first, then port 1
      do_reset();
      p0_write = 1'b1; p0_addr = 16'h0010; p0_wdata = 8'hC1;
      p1_read  = 1'b1; p1_addr = 16'h0020;
      do_txn("simul.p0", 0, 3'b010, 16'h0010, 8'hC1, 2, 8'h01);
      p0_write = 1'b0;
      do_txn("simul.p1", 1, 3'b100, 16'h0020, 8'h00, 3, 8'hB2);
      clear_reqs();

      // Starvation: both ports request continuously -> 0,0,0,1,0,0,0,1
      do_reset();
      p0_read = 1'b1; p0_addr = 16'h0100;
      p1_read = 1'b1; p1_addr = 16'h0200;
      for (int i = 0; i < 8; i++) begin
         if ((i % 4) == 3)
            do_txn($sformatf("starve%0d", i), 1, 3'b100, 16'h0200, 8'h00, 1, 8'(8'h40 + i));
         else
            do_txn($sformatf("starve%0d", i), 0, 3'b100, 16'h0100, 8'h00, 1, 8'(8'h40 + i));
      end
      clear_reqs();

      // Lock: saturate the counter, then locked grants must not disturb it
      do_reset();
      p0_read = 1'b1; p0_addr = 16'h0300;
      p1_read = 1'b1; p1_addr = 16'h0400;
      for (int i = 0; i < 3; i++)
         do_txn($sformatf("prelock%0d", i), 0, 3'b100, 16'h0300, 8'h00, 1, 8'(8'h60 + i));
      p0_lock = 1'b1;
      for (int i = 0; i < 6; i++)
         do_txn($sformatf("lock%0d", i), 0, 3'b100, 16'h0300, 8'h00, 2, 8'(8'h70 + i));
      p0_lock = 1'b0;
      do_txn("unlock", 1, 3'b100, 16'h0400, 8'h00, 1, 8'h7F);
      clear_reqs();

      // Reset in the middle of a port-1 write
      do_reset();
      p1_write = 1'b1; p1_addr = 16'h0BEE; p1_wdata = 8'h99;
      tick();
      chk("rstmid.grant", 32'(grant), 32'h2);
      chk("rstmid.write", 32'(memory_write), 32'h1);
      tick();
      memory_rdata = 8'hDD;
      memory_done  = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("rstmid.grant0", 32'(grant), 32'h0);
      chk("rstmid.rw0",    32'({memory_read, memory_write, memory_io}), 32'h0);
      chk("rstmid.addr0",  32'(memory_addr), 32'h0);
      chk("rstmid.wdata0", 32'(memory_wdata), 32'h0);
      chk("rstmid.nodone", 32'({p1_done, p0_done}), 32'h0);
      chk("rstmid.rdata",  32'(p1_rdata), 32'h0);
      memory_done  = 1'b0;
      memory_rdata = 8'h00;
      clear_reqs();
      tick();
      rst_n = 1'b1;
      #1;
      p0_read = 1'b1; p0_addr = 16'h00C3;
      do_txn("postrst", 0, 3'b100, 16'h00C3, 8'h00, 2, 8'hE1);
      clear_reqs();

      // Stray completion while idle, then a read+write request on port 1
      do_reset();
      memory_rdata = 8'hEE;
      memory_done  = 1'b1;
      #1;
      chk("stray.done", 32'({p1_done, p0_done}), 32'h0);
      tick();
      memory_done  = 1'b0;
      memory_rdata = 8'h00;
      #1;
      chk("stray.grant", 32'(grant), 32'h0);
      chk("stray.rdata", 32'({p1_rdata, p0_rdata}), 32'h0);
      p1_read = 1'b1; p1_write = 1'b1; p1_addr = 16'h0055; p1_wdata = 8'h5C;
      do_txn("rdwr.p1", 1, 3'b100, 16'h0055, 8'h5C, 1, 8'h3D);
      clear_reqs();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
